// File: rtl/stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch core.
//   bcd4_t              : one BCD digit
//   PRESET_LO/PRESET_HI : the two fixed preset times (d3 d2 d1 d0), 10:20 and 40:30
//   D*_MIN/D*_MAX       : legal range of each digit position
package stopwatch_pkg;

    typedef logic [3:0] bcd4_t;

    localparam logic [15:0] PRESET_LO = 16'h1020;
    localparam logic [15:0] PRESET_HI = 16'h4030;

    localparam bcd4_t D0_MIN = 4'd0;
    localparam bcd4_t D0_MAX = 4'd9;
    localparam bcd4_t D1_MIN = 4'd0;
    localparam bcd4_t D1_MAX = 4'd5;
    localparam bcd4_t D2_MIN = 4'd0;
    localparam bcd4_t D2_MAX = 4'd9;
    localparam bcd4_t D3_MIN = 4'd1;
    localparam bcd4_t D3_MAX = 4'd4;

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit, wrapping between MIN and MAX.
//   clk    : system clock
//   RESET  : synchronous, active-high; loads load_val
//   load_val : value taken on RESET
//   en     : step the digit this clock
//   down   : 1 = decrement, 0 = increment
//   digit  : current digit value
//   term   : digit is at the wrap point for the current direction
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter bcd4_t MIN = 4'd0,
    parameter bcd4_t MAX = 4'd9
) (
    input  logic  clk,
    input  logic  RESET,
    input  bcd4_t load_val,
    input  logic  en,
    input  logic  down,
    output bcd4_t digit,
    output logic  term
);

    bcd4_t digit_q;
    bcd4_t digit_d;
    logic  can_inc;
    logic  can_dec;

    // Out-of-range values (only reachable by forcing) fall into the
    // wrap branch: increment goes to MIN, decrement goes to MAX.
    always_comb begin
        can_inc = (digit_q == MIN) || ((digit_q > MIN) && (digit_q < MAX));
        can_dec = (digit_q > MIN) && (digit_q <= MAX);
        digit_d = digit_q;
        if (en) begin
            if (down) begin
                digit_d = can_dec ? (digit_q - 4'd1) : MAX;
            end else begin
                digit_d = can_inc ? (digit_q + 4'd1) : MIN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            digit_q <= load_val;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign term  = down ? (digit_q == MIN) : (digit_q == MAX);

endmodule

// File: rtl/bcd_stopwatch_core.sv
// Four-digit BCD up/down stopwatch counting between 10:20 and 40:30.
//   clk      : system clock
//   RESET    : synchronous, active-high; loads the start preset for REVERSE
//   START    : level run enable
//   REVERSE  : 0 = count up, 1 = count down
//   Q        : BCD count {d3, d2, d1, d0} (mm:ss)
//   at_limit : combinational; Q equals the stop preset for REVERSE
module bcd_stopwatch_core
    import stopwatch_pkg::*;
(
    input  logic        clk,
    input  logic        RESET,
    input  logic        START,
    input  logic        REVERSE,
    output logic [15:0] Q,
    output logic        at_limit
);

    bcd4_t       d0, d1, d2, d3;
    logic        t0, t1, t2;
    logic        t3_unused;
    logic [15:0] load_val;
    logic [15:0] target;
    logic        run;
    logic        e0, e1, e2, e3;

    assign Q = {d3, d2, d1, d0};

    // Direction picks both the reload preset and the stop preset; they
    // are always opposite ends of the range.
    always_comb begin
        load_val = REVERSE ? PRESET_HI : PRESET_LO;
        target   = REVERSE ? PRESET_LO : PRESET_HI;
        at_limit = (Q == target);
        run      = START & ~at_limit;
        e0       = run;
        e1       = run & t0;
        e2       = run & t0 & t1;
        e3       = run & t0 & t1 & t2;
    end

    bcd_digit_counter #(.MIN(D0_MIN), .MAX(D0_MAX)) u_d0 (
        .clk(clk), .RESET(RESET), .load_val(load_val[3:0]),
        .en(e0), .down(REVERSE), .digit(d0), .term(t0)
    );

    bcd_digit_counter #(.MIN(D1_MIN), .MAX(D1_MAX)) u_d1 (
        .clk(clk), .RESET(RESET), .load_val(load_val[7:4]),
        .en(e1), .down(REVERSE), .digit(d1), .term(t1)
    );

    bcd_digit_counter #(.MIN(D2_MIN), .MAX(D2_MAX)) u_d2 (
        .clk(clk), .RESET(RESET), .load_val(load_val[11:8]),
        .en(e2), .down(REVERSE), .digit(d2), .term(t2)
    );

    // The stop compare prevents d3 from ever wrapping, so its flag is unused.
    bcd_digit_counter #(.MIN(D3_MIN), .MAX(D3_MAX)) u_d3 (
        .clk(clk), .RESET(RESET), .load_val(load_val[15:12]),
        .en(e3), .down(REVERSE), .digit(d3), .term(t3_unused)
    );

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Self-checking bench for bcd_stopwatch_core. The reference model keeps
// the time as a plain number of seconds and converts to mm:ss BCD.
module tb_bcd_stopwatch_core;

    logic        clk = 1'b0;
    logic        RESET;
    logic        START;
    logic        REVERSE;
    logic [15:0] Q;
    logic        at_limit;

    int n_checks = 0;
    int n_fail   = 0;
    int m_secs   = 0;

    localparam int LO_S = 10 * 60 + 20;
    localparam int HI_S = 40 * 60 + 30;

    bcd_stopwatch_core dut (
        .clk(clk), .RESET(RESET), .START(START), .REVERSE(REVERSE),
        .Q(Q), .at_limit(at_limit)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int s);
        int m;
        int x;
        m = s / 60;
        x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic int target_s(input logic rev);
        return rev ? LO_S : HI_S;
    endfunction

    // Drive inputs, take one edge, advance the model, settle 1 ns.
    task automatic tick(input logic rst, input logic st, input logic rev);
        RESET   = rst;
        START   = st;
        REVERSE = rev;
        @(posedge clk);
        if (rst) m_secs = rev ? HI_S : LO_S;
        else if (st && (m_secs != target_s(rev))) m_secs += rev ? -1 : 1;
        #1;
    endtask

    task automatic run_to(input int secs, input logic rev);
        int guard = 0;
        while ((m_secs != secs) && (guard < 4000)) begin
            tick(1'b0, 1'b1, rev);
            guard++;
        end
        n_checks++;
        if (m_secs != secs) begin
            n_fail++;
            $display("FAIL run_to_bound: model at %0d s, required %0d s", m_secs, secs);
        end
    endtask

    task automatic test_reset;
        tick(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (Q !== 16'h1020) begin
            n_fail++; $display("FAIL reset_up_q: got %h, expected 1020", Q);
        end
        n_checks++;
        if (at_limit !== 1'b0) begin
            n_fail++; $display("FAIL reset_up_limit: got %b, expected 0", at_limit);
        end
    endtask

    task automatic test_up_carry;
        tick(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (Q !== 16'h1021) begin
            n_fail++; $display("FAIL up_first_step: got %h, expected 1021", Q);
        end
        for (int i = 0; i < 9; i++) tick(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (Q !== 16'h1030 || Q !== to_bcd(m_secs)) begin
            n_fail++; $display("FAIL up_d0_carry: got %h, expected 1030", Q);
        end
    endtask

    task automatic test_rollovers;
        run_to(10 * 60 + 59, 1'b0);
        n_checks++;
        if (Q !== 16'h1059) begin
            n_fail++; $display("FAIL up_reach_1059: got %h, expected 1059", Q);
        end
        tick(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (Q !== 16'h1100) begin
            n_fail++; $display("FAIL up_d1_carry: got %h, expected 1100", Q);
        end
        run_to(19 * 60 + 59, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (Q !== 16'h2000) begin
            n_fail++; $display("FAIL up_d2_carry: got %h, expected 2000", Q);
        end
        run_to(HI_S, 1'b0);
        n_checks++;
        if (Q !== 16'h4030 || at_limit !== 1'b1) begin
            n_fail++; $display("FAIL up_stop: got %h/%b, expected 4030/1", Q, at_limit);
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            n_checks++;
            if (Q !== 16'h4030 || at_limit !== 1'b1) begin
                n_fail++; $display("FAIL up_frozen: got %h/%b, expected 4030/1", Q, at_limit);
            end
        end
    endtask

    task automatic test_down;
        tick(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (Q !== 16'h4030 || at_limit !== 1'b0) begin
            n_fail++; $display("FAIL reset_down: got %h/%b, expected 4030/0", Q, at_limit);
        end
        tick(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (Q !== 16'h4029) begin
            n_fail++; $display("FAIL down_first_step: got %h, expected 4029", Q);
        end
        run_to(40 * 60, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (Q !== 16'h3959) begin
            n_fail++; $display("FAIL down_borrow: got %h, expected 3959", Q);
        end
        run_to(LO_S, 1'b1);
        n_checks++;
        if (Q !== 16'h1020 || at_limit !== 1'b1) begin
            n_fail++; $display("FAIL down_stop: got %h/%b, expected 1020/1", Q, at_limit);
        end
        tick(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (Q !== 16'h1020) begin
            n_fail++; $display("FAIL down_frozen: got %h, expected 1020", Q);
        end
    endtask

    task automatic test_hold;
        tick(1'b1, 1'b0, 1'b0);
        run_to(23 * 60 + 45, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            n_checks++;
            if (Q !== 16'h2345) begin
                n_fail++; $display("FAIL hold: got %h, expected 2345", Q);
            end
        end
        tick(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (Q !== 16'h2346) begin
            n_fail++; $display("FAIL resume: got %h, expected 2346", Q);
        end
    endtask

    task automatic test_reverse_at_limit;
        run_to(HI_S, 1'b0);
        n_checks++;
        if (at_limit !== 1'b1) begin
            n_fail++; $display("FAIL limit_before_rev: got %b, expected 1", at_limit);
        end
        REVERSE = 1'b1;
        #1;
        n_checks++;
        if (at_limit !== 1'b0) begin
            n_fail++; $display("FAIL limit_after_rev: got %b, expected 0", at_limit);
        end
        tick(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (Q !== 16'h4029) begin
            n_fail++; $display("FAIL rev_resume: got %h, expected 4029", Q);
        end
        run_to(30 * 60, 1'b1);
        n_checks++;
        if (Q !== 16'h3000) begin
            n_fail++; $display("FAIL reach_3000: got %h, expected 3000", Q);
        end
        tick(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (Q !== 16'h4030) begin
            n_fail++; $display("FAIL reset_mid_count: got %h, expected 4030", Q);
        end
    endtask

    task automatic test_random;
        logic rev = 1'b0;
        logic rst, st;
        tick(1'b1, 1'b0, rev);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) rev = ~rev;
            rst = ($urandom_range(0, 79) == 0);
            st  = ($urandom_range(0, 3) != 0);
            tick(rst, st, rev);
            n_checks++;
            if (Q !== to_bcd(m_secs) || at_limit !== (m_secs == target_s(rev))) begin
                n_fail++;
                $display("FAIL random_step %0d: got %h/%b, expected %h/%b", i, Q, at_limit,
                         to_bcd(m_secs), (m_secs == target_s(rev)));
            end
        end
    endtask

    initial begin
        RESET   = 1'b1;
        START   = 1'b0;
        REVERSE = 1'b0;
        test_reset;
        test_up_carry;
        test_rollovers;
        test_down;
        test_hold;
        test_reverse_at_limit;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
